// File: rtl/mc_power_pkg.sv
// Shared types and constants for the memory-controller power sequencer.
package mc_power_pkg;

   localparam int CNT_W           = 8;
   localparam int SAVE_CYC_DEF    = 2;
   localparam int RESTORE_CYC_DEF = 2;
   localparam int STEP_CYC_DEF    = 1;
   localparam int ACK_TIMEOUT_DEF = 16;

   typedef enum logic [3:0] {
      ST_ON       = 4'd0,
      ST_SAVE     = 4'd1,
      ST_ISO_ON   = 4'd2,
      ST_CLK_OFF  = 4'd3,
      ST_PWR_OFF  = 4'd4,
      ST_SRAM_OFF = 4'd5,
      ST_OFF      = 4'd6,
      ST_SRAM_ON  = 4'd7,
      ST_PWR_ON   = 4'd8,
      ST_CLK_ON   = 4'd9,
      ST_RESTORE  = 4'd10,
      ST_ISO_OFF  = 4'd11,
      ST_ERR      = 4'd12
   } pwr_state_t;

   typedef struct packed {
      logic pwr;
      logic save;
      logic restore;
      logic iso;
      logic clk_gate;
      logic sram;
   } dom_ctrl_t;

   localparam dom_ctrl_t CTRL_RST = '{pwr: 1'b1, save: 1'b0, restore: 1'b0,
                                      iso: 1'b0, clk_gate: 1'b1, sram: 1'b0};

   // A count of N cycles loads N-1: the entry edge is the first cycle.
   function automatic logic [CNT_W-1:0] cyc_load(input int unsigned cyc);
      return CNT_W'(cyc - 1);
   endfunction

endpackage

// File: rtl/pwr_step_timer.sv
// Loadable down-counter; done while the count sits at zero.
module pwr_step_timer
   import mc_power_pkg::*;
(
   input  logic             clk,
   input  logic             rstn,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] cnt;

   // Load on request, otherwise count down and stick at zero.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/mc_power_ctrl.sv
// Memory-controller power-domain sequencer (always-on domain).
//
// state    | meaning
// ON       | domain powered and running, waiting for pd_req
// SAVE     | retention save strobe high
// ISO_ON   | outputs clamped
// CLK_OFF  | controller clock stopped
// PWR_OFF  | supply removed, waiting for ack low
// SRAM_OFF | SRAM powered down
// OFF      | domain fully off, waiting for pu_req
// SRAM_ON  | SRAM powered back up
// PWR_ON   | supply restored, waiting for ack high
// CLK_ON   | controller clock running again
// RESTORE  | retention restore strobe high
// ISO_OFF  | clamps released
// ERR      | ack timeout, outputs frozen until reset
module mc_power_ctrl
   import mc_power_pkg::*;
#(
   parameter int SAVE_CYC    = SAVE_CYC_DEF,
   parameter int RESTORE_CYC = RESTORE_CYC_DEF,
   parameter int STEP_CYC    = STEP_CYC_DEF,
   parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
)(
   input  logic clk,
   input  logic rstn,
   input  logic pd_req,
   input  logic pu_req,
   input  logic sram_pd_en,
   input  logic mc_pwr_ack,
   output logic mc_pwr,
   output logic mc_save,
   output logic mc_restore,
   output logic mc_iso,
   output logic mc_clk_gate,
   output logic sram_pwr,
   output logic busy,
   output logic off,
   output logic err
);

   pwr_state_t       state, state_nxt;
   dom_ctrl_t        ctrl, ctrl_nxt;
   logic             sram_lat;
   logic             tmr_load, tmr_done;
   logic [CNT_W-1:0] tmr_val;

   // Sequencing: dwell states leave on timer done, ack states on ack level.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_ON:       if (pd_req)   state_nxt = ST_SAVE;
         ST_SAVE:     if (tmr_done) state_nxt = ST_ISO_ON;
         ST_ISO_ON:   if (tmr_done) state_nxt = ST_CLK_OFF;
         ST_CLK_OFF:  if (tmr_done) state_nxt = ST_PWR_OFF;
         ST_PWR_OFF: begin
            if (!mc_pwr_ack)   state_nxt = sram_lat ? ST_SRAM_OFF : ST_OFF;
            else if (tmr_done) state_nxt = ST_ERR;
         end
         ST_SRAM_OFF: if (tmr_done) state_nxt = ST_OFF;
         ST_OFF:      if (pu_req)   state_nxt = sram_lat ? ST_SRAM_ON : ST_PWR_ON;
         ST_SRAM_ON:  if (tmr_done) state_nxt = ST_PWR_ON;
         ST_PWR_ON: begin
            if (mc_pwr_ack)    state_nxt = ST_CLK_ON;
            else if (tmr_done) state_nxt = ST_ERR;
         end
         ST_CLK_ON:   if (tmr_done) state_nxt = ST_RESTORE;
         ST_RESTORE:  if (tmr_done) state_nxt = ST_ISO_OFF;
         ST_ISO_OFF:  if (tmr_done) state_nxt = ST_ON;
         ST_ERR:      state_nxt = ST_ERR;
         default:     state_nxt = ST_ON;
      endcase
   end

   // Timer reload value for the state being entered.
   always_comb begin
      tmr_val = '0;
      case (state_nxt)
         ST_SAVE:                tmr_val = cyc_load(SAVE_CYC);
         ST_RESTORE:             tmr_val = cyc_load(RESTORE_CYC);
         ST_PWR_OFF, ST_PWR_ON:  tmr_val = cyc_load(ACK_TIMEOUT);
         ST_ISO_ON, ST_CLK_OFF, ST_SRAM_OFF,
         ST_SRAM_ON, ST_CLK_ON, ST_ISO_OFF:
                                 tmr_val = cyc_load(STEP_CYC);
         default:                tmr_val = '0;
      endcase
   end

   assign tmr_load = (state_nxt != state);

   pwr_step_timer u_timer (
      .clk      (clk),
      .rstn     (rstn),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // Controls are cumulative: each state touches only its own control.
   always_comb begin
      ctrl_nxt = ctrl;
      case (state_nxt)
         ST_SAVE:     ctrl_nxt.save = 1'b1;
         ST_ISO_ON: begin
            ctrl_nxt.save = 1'b0;
            ctrl_nxt.iso  = 1'b1;
         end
         ST_CLK_OFF:  ctrl_nxt.clk_gate = 1'b0;
         ST_PWR_OFF:  ctrl_nxt.pwr      = 1'b0;
         ST_SRAM_OFF: ctrl_nxt.sram     = 1'b1;
         ST_SRAM_ON:  ctrl_nxt.sram     = 1'b0;
         ST_PWR_ON:   ctrl_nxt.pwr      = 1'b1;
         ST_CLK_ON:   ctrl_nxt.clk_gate = 1'b1;
         ST_RESTORE:  ctrl_nxt.restore  = 1'b1;
         ST_ISO_OFF: begin
            ctrl_nxt.restore = 1'b0;
            ctrl_nxt.iso     = 1'b0;
         end
         default:     ctrl_nxt = ctrl;
      endcase
   end

   // State and registered outputs, decoded from the next state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= ST_ON;
         ctrl  <= CTRL_RST;
         busy  <= 1'b0;
         off   <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         ctrl  <= ctrl_nxt;
         busy  <= !(state_nxt inside {ST_ON, ST_OFF, ST_ERR});
         off   <= (state_nxt == ST_OFF);
         err   <= (state_nxt == ST_ERR);
      end
   end

   // SRAM power-down choice is captured once, when leaving ON.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sram_lat <= 1'b0;
      end else if (state == ST_ON && pd_req) begin
         sram_lat <= sram_pd_en;
      end
   end

   assign mc_pwr      = ctrl.pwr;
   assign mc_save     = ctrl.save;
   assign mc_restore  = ctrl.restore;
   assign mc_iso      = ctrl.iso;
   assign mc_clk_gate = ctrl.clk_gate;
   assign sram_pwr    = ctrl.sram;

endmodule

// File: tb/tb_mc_power_ctrl.sv
// Self-checking bench for mc_power_ctrl: step-list reference model plus directed edge checks.
module tb_mc_power_ctrl;

   localparam int SAVE_C = 2;
   localparam int REST_C = 2;
   localparam int STEP_C = 1;
   localparam int ACK_TO = 16;

   localparam int MD_ON = 0, MD_DOWN = 1, MD_OFF = 2, MD_UP = 3, MD_ERR = 4;

   // control vector order: pwr save restore iso clk_gate sram
   localparam logic [5:0] V_ON = 6'b100010;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic pd_req = 1'b0, pu_req = 1'b0, sram_pd_en = 1'b0, mc_pwr_ack = 1'b1;
   logic mc_pwr, mc_save, mc_restore, mc_iso, mc_clk_gate, sram_pwr, busy, off, err;

   int tests = 0;
   int fails = 0;
   int ack_lat = 0;
   bit ack_stuck = 1'b0;

   mc_power_ctrl #(
      .SAVE_CYC(SAVE_C), .RESTORE_CYC(REST_C), .STEP_CYC(STEP_C), .ACK_TIMEOUT(ACK_TO)
   ) dut (
      .clk(clk), .rstn(rstn), .pd_req(pd_req), .pu_req(pu_req),
      .sram_pd_en(sram_pd_en), .mc_pwr_ack(mc_pwr_ack),
      .mc_pwr(mc_pwr), .mc_save(mc_save), .mc_restore(mc_restore),
      .mc_iso(mc_iso), .mc_clk_gate(mc_clk_gate), .sram_pwr(sram_pwr),
      .busy(busy), .off(off), .err(err)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: run did not end, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   // ---------------- reference model: a queue of pending sequence steps ----------------
   typedef struct {
      logic [5:0] vec;
      int         dur;
      int         lvl;   // -1 = timed dwell, 0/1 = wait for that ack level
   } step_t;

   step_t      q[$];
   int         m_mode;
   int         age;
   logic [5:0] m_vec;
   bit         m_sram;

   task automatic push_step(input logic [5:0] v, input int d, input int l);
      step_t s;
      s.vec = v; s.dur = d; s.lvl = l;
      q.push_back(s);
   endtask

   task automatic m_reset();
      q.delete();
      m_mode = MD_ON; age = 0; m_vec = V_ON; m_sram = 1'b0;
   endtask

   task automatic m_advance();
      void'(q.pop_front());
      age = 0;
      if (q.size() == 0) m_mode = (m_mode == MD_DOWN) ? MD_OFF : MD_ON;
      else m_vec = q[0].vec;
   endtask

   task automatic m_step();
      case (m_mode)
         MD_ON: if (pd_req) begin
            m_sram = sram_pd_en;
            push_step(6'b110010, SAVE_C, -1);
            push_step(6'b100110, STEP_C, -1);
            push_step(6'b100100, STEP_C, -1);
            push_step(6'b000100, 0, 0);
            if (m_sram) push_step(6'b000101, STEP_C, -1);
            m_mode = MD_DOWN; age = 0; m_vec = q[0].vec;
         end
         MD_OFF: if (pu_req) begin
            if (m_sram) push_step(6'b000100, STEP_C, -1);
            push_step(6'b100100, 0, 1);
            push_step(6'b100110, STEP_C, -1);
            push_step(6'b101110, REST_C, -1);
            push_step(6'b100010, STEP_C, -1);
            m_mode = MD_UP; age = 0; m_vec = q[0].vec;
         end
         MD_DOWN, MD_UP: begin
            if (q[0].lvl >= 0) begin
               if (mc_pwr_ack == (q[0].lvl == 1)) m_advance();
               else if (age + 1 >= ACK_TO)       m_mode = MD_ERR;
               else                              age++;
            end else if (age + 1 >= q[0].dur) m_advance();
            else age++;
         end
         default: ;
      endcase
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge rstn);
         if (!rstn) m_reset();
         else m_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      logic [8:0] got, exp;
      forever begin
         @(negedge clk);
         got = {mc_pwr, mc_save, mc_restore, mc_iso, mc_clk_gate, sram_pwr, busy, off, err};
         exp = {m_vec, (m_mode == MD_DOWN || m_mode == MD_UP), (m_mode == MD_OFF), (m_mode == MD_ERR)};
         tests++;
         if (got !== exp) begin
            fails++;
            $display("FAIL model_cmp t=%0t got=%b required=%b (pwr save rst iso clk sram busy off err)",
                     $time, got, exp);
         end
      end
   end

   // ---------------- responsive ack emulation ----------------
   initial begin
      int lag;
      lag = 0;
      forever begin
         @(negedge clk);
         if (!ack_stuck) begin
            if (mc_pwr_ack != mc_pwr) begin
               if (lag >= ack_lat) begin
                  mc_pwr_ack = mc_pwr;
                  lag = 0;
               end else lag++;
            end else lag = 0;
         end
      end
   end

   task automatic lit(input string name, input logic got, input logic exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%b required=%b t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s got=%0d required=%0d", name, got, exp);
      end
   endtask

   // Call just after a negedge: reset asserted mid-cycle, outputs checked before any clock edge.
   task automatic pulse_reset(input bit check);
      #1 rstn = 1'b0;
      #1;
      if (check) begin
         lit("rst_async_pwr", mc_pwr, 1'b1);
         lit("rst_async_clk", mc_clk_gate, 1'b1);
         lit("rst_async_iso", mc_iso, 1'b0);
         lit("rst_async_busy", busy, 1'b0);
      end
      @(posedge clk);
      #2 rstn = 1'b1;
      mc_pwr_ack = 1'b1;
   endtask

   // Power-up from OFF; returns edge index at which ON was re-entered (-1 on timeout).
   task automatic do_pu(output int on_edge, output int n_rest);
      on_edge = -1; n_rest = 0;
      @(negedge clk);
      pu_req = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         pu_req = 1'b0;
         if (mc_restore) n_rest++;
         if (!busy && !off) begin
            on_edge = i;
            break;
         end
      end
   endtask

   initial begin
      int on_edge, n_rest;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rstn = 1'b1;

      // idle after reset
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         lit("idle_busy", busy, 1'b0);
      end
      lit("idle_pwr", mc_pwr, 1'b1);
      lit("idle_clk", mc_clk_gate, 1'b1);
      lit("idle_iso", mc_iso, 1'b0);

      // power-down with SRAM, ack falls 2 cycles after mc_pwr drops
      @(negedge clk);
      ack_lat = 1; sram_pd_en = 1'b1; pd_req = 1'b1;
      for (int e = 0; e <= 7; e++) begin
         @(negedge clk);
         pd_req = 1'b0;
         case (e)
            0: begin lit("pd_e0_save", mc_save, 1'b1); lit("pd_e0_busy", busy, 1'b1); end
            1: lit("pd_e1_save", mc_save, 1'b1);
            2: begin lit("pd_e2_save", mc_save, 1'b0); lit("pd_e2_iso", mc_iso, 1'b1); end
            3: begin lit("pd_e3_clk", mc_clk_gate, 1'b0); lit("pd_e3_pwr", mc_pwr, 1'b1); end
            4: lit("pd_e4_pwr", mc_pwr, 1'b0);
            5: lit("pd_e5_sram", sram_pwr, 1'b0);
            6: begin lit("pd_e6_sram", sram_pwr, 1'b1); lit("pd_e6_off", off, 1'b0); end
            default: lit("pd_e7_off", off, 1'b1);
         endcase
      end

      do_pu(on_edge, n_rest);
      chk_int("pu_sram_on_edge", on_edge, 7);
      chk_int("pu_sram_restore_cycles", n_rest, REST_C);
      lit("pu_iso_released", mc_iso, 1'b0);
      lit("pu_sram_up", sram_pwr, 1'b0);

      // power-down without SRAM
      @(negedge clk);
      sram_pd_en = 1'b0; pd_req = 1'b1;
      for (int e = 0; e <= 6; e++) begin
         @(negedge clk);
         pd_req = 1'b0;
         if (e == 5) lit("pdn_e5_off", off, 1'b0);
         if (e == 6) begin lit("pdn_e6_off", off, 1'b1); lit("pdn_e6_sram", sram_pwr, 1'b0); end
      end
      do_pu(on_edge, n_rest);
      chk_int("pu_nosram_on_edge", on_edge, 6);
      chk_int("pu_nosram_restore_cycles", n_rest, REST_C);

      // both requests in ON: power-down wins
      @(negedge clk);
      pd_req = 1'b1; pu_req = 1'b1; sram_pd_en = 1'b1;
      @(negedge clk);
      pd_req = 1'b0; pu_req = 1'b0;
      lit("both_req_save", mc_save, 1'b1);
      lit("both_req_busy", busy, 1'b1);
      repeat (20) @(negedge clk);
      lit("both_req_off", off, 1'b1);

      // randomized traffic with a responsive ack
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         pd_req     = ($urandom_range(0, 7) == 0);
         pu_req     = ($urandom_range(0, 7) == 0);
         sram_pd_en = $urandom_range(0, 1);
         if ($urandom_range(0, 31) == 0) ack_lat = $urandom_range(0, 4);
      end
      pd_req = 1'b0; pu_req = 1'b0;

      // stuck ack: timeout to ERR, frozen and deaf to pu_req
      pulse_reset(1'b0);
      ack_lat = 1;
      @(negedge clk);
      ack_stuck = 1'b1; mc_pwr_ack = 1'b1; pd_req = 1'b1;
      for (int e = 0; e <= 20; e++) begin
         @(negedge clk);
         pd_req = 1'b0;
         if (e == 19) lit("to_e19_err", err, 1'b0);
         if (e == 20) begin
            lit("to_e20_err", err, 1'b1);
            lit("to_e20_iso", mc_iso, 1'b1);
            lit("to_e20_clk", mc_clk_gate, 1'b0);
            lit("to_e20_busy", busy, 1'b0);
         end
      end
      pu_req = 1'b1;
      repeat (10) @(negedge clk);
      pu_req = 1'b0;
      lit("err_sticky", err, 1'b1);
      lit("err_pwr_frozen", mc_pwr, 1'b0);
      pulse_reset(1'b0);
      ack_stuck = 1'b0;
      @(negedge clk);
      lit("err_cleared", err, 1'b0);

      // reset asserted during CLK_OFF
      @(negedge clk);
      pd_req = 1'b1;
      for (int e = 0; e <= 3; e++) begin
         @(negedge clk);
         pd_req = 1'b0;
      end
      lit("clkoff_gate_low", mc_clk_gate, 1'b0);
      pulse_reset(1'b1);
      repeat (5) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
